// File: rtl/alu_pkg.sv
// alu_pkg: ALU unit encodings, mul_seq state enum and iteration bound shared by alu and mul_seq.
package alu_pkg;
  typedef enum logic [2:0] {
    U_ADD      = 3'b000,
    U_AND      = 3'b001,
    U_SHIFT    = 3'b010,
    U_PASS_SRC = 3'b011,
    U_OR       = 3'b100,
    U_XOR      = 3'b101,
    U_PASS_ACC = 3'b111
  } alu_unit_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_DONE
  } mul_state_e;
  localparam logic [2:0] ITER_LAST = 3'd7;
endpackage

// File: rtl/alu.sv
// alu: 8-bit combinational ALU; op_sel picks subtract for ADD and right shift for SHIFT.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] acc_i,
  input  logic [7:0] src_i,
  input  logic [2:0] unit_sel_i,
  input  logic       op_sel_i,
  output logic [7:0] result_o
);
  always_comb begin
    result_o = '0;
    case (unit_sel_i)
      U_ADD:      result_o = op_sel_i ? acc_i - src_i : acc_i + src_i;
      U_AND:      result_o = acc_i & src_i;
      U_SHIFT:    result_o = op_sel_i ? acc_i >> src_i[2:0] : acc_i << src_i[2:0];
      U_PASS_SRC: result_o = src_i;
      U_OR:       result_o = acc_i | src_i;
      U_XOR:      result_o = acc_i ^ src_i;
      U_PASS_ACC: result_o = acc_i;
      default:    result_o = '0;
    endcase
  end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: shift-add 8x8 multiplier (low 8 bits) sharing one ALU, one operation per cycle.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq
  import alu_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       busy_out,
  output logic       done_out,
  output logic [7:0] result_out
);
`ifdef MUL_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  mul_state_e state_q, state_d;
  logic [7:0] mcand_q, mcand_d, mplr_q, mplr_d, prod_q, prod_d, result_q, result_d;
  logic [2:0] iter_q, iter_d;
  logic [7:0] alu_acc, alu_src, alu_res;
  logic [2:0] alu_unit;
  logic       alu_op;

  alu alu_0 (
    .acc_i      (alu_acc),
    .src_i      (alu_src),
    .unit_sel_i (alu_unit),
    .op_sel_i   (alu_op),
    .result_o   (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    prod_d   = prod_q;
    iter_d   = iter_q;
    alu_acc  = prod_q;
    alu_src  = mcand_q;
    alu_unit = U_PASS_ACC;
    alu_op   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_in) begin
        mcand_d = a_in;
        mplr_d  = b_in;
        prod_d  = '0;
        iter_d  = '0;
        state_d = (EARLY && b_in == 8'd0) ? ST_DONE : ST_ADD;
      end
      ST_ADD: begin
        alu_unit = mplr_q[0] ? U_ADD : U_PASS_ACC;
        prod_d   = alu_res;
        state_d  = ST_SHL;
      end
      ST_SHL: begin
        alu_acc  = mcand_q;
        alu_src  = 8'd1;
        alu_unit = U_SHIFT;
        mcand_d  = alu_res;
        state_d  = ST_SHR;
      end
      ST_SHR: begin
        alu_acc  = mplr_q;
        alu_src  = 8'd1;
        alu_unit = U_SHIFT;
        alu_op   = 1'b1;
        mplr_d   = alu_res;
        iter_d   = iter_q + 3'd1;
        state_d  = (iter_q == ITER_LAST || (EARLY && alu_res == 8'd0)) ? ST_DONE : ST_ADD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The product is final whenever DONE is about to be entered.
  assign result_d = (state_d == ST_DONE && state_q != ST_DONE) ? prod_d : result_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prod_q   <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      prod_q   <= prod_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  assign busy_out   = state_q != ST_IDLE;
  assign done_out   = state_q == ST_DONE;
  assign result_out = result_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized and directed checks of mul_seq against a cycle-count/product model.
module tb_mul_seq;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic       clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       busy_out, done_out;
  logic [7:0] result_out;
  int         checks = 0, failures = 0;
  bit         chk_en = 1'b0;
  bit         m_busy = 1'b0, m_done = 1'b0;
  logic [7:0] m_res = '0, m_pend = '0;
  int         m_left = 0;

  always #5 clk_in = ~clk_in;

  mul_seq dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  function automatic logic [7:0] prod8(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[7:0];
  endfunction

  // Cycles from accept to done: one cycle per state (add, shift, shift) per multiplier bit, plus DONE.
  function automatic int lat(input logic [7:0] b);
    if (!EARLY) return 25;
    if (b == 8'd0) return 1;
    for (int i = 7; i >= 0; i--) if (b[i]) return 3 * (i + 1) + 1;
    return 25;
  endfunction

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else if (start_in) begin
      m_busy <= 1'b1;
      m_pend <= prod8(a_in, b_in);
      m_left <= lat(b_in) - 1;
      if (lat(b_in) == 1) begin
        m_done <= 1'b1;
        m_res  <= prod8(a_in, b_in);
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      checks++;
      if ({busy_out, done_out, result_out} !== {m_busy, m_done, m_res}) begin
        failures++;
        $display("FAIL cycle t=%0t got busy=%b done=%b res=%h exp busy=%b done=%b res=%h",
                 $time, busy_out, done_out, result_out, m_busy, m_done, m_res);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done_out && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    if (!done_out) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=no_done exp=done within 60 cycles");
    end
  endtask

  task automatic mul(input logic [7:0] a, input logic [7:0] b, output logic [7:0] r, output int n);
    start_in = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(n);
    r = result_out;
    @(negedge clk_in);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_timeout", 32'(busy_out), 32'd0);
  endtask

  initial begin
    logic [7:0] r, a, b;
    int n, dones;
    start_in = 1'b1;
    a_in     = 8'h12;
    b_in     = 8'h34;
    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_result", 32'(result_out), 32'd0);
    rst_in   = 1'b0;
    start_in = 1'b0;
    @(negedge clk_in);
    mul(8'd13, 8'd11, r, n);
    check("13x11_result", 32'(r), 32'h8F);
    check("13x11_latency", 32'(n), EARLY ? 32'd13 : 32'd25);
    mul(8'hFF, 8'hFF, r, n);
    check("ffxff_result", 32'(r), 32'h01);
    check("ffxff_latency", 32'(n), 32'd25);
    mul(8'h10, 8'h10, r, n);
    check("10x10_result", 32'(r), 32'h00);
    mul(8'd5, 8'd6, r, n);
    check("5x6_result", 32'(r), 32'h1E);
    start_in = 1'b1;
    a_in     = 8'd7;
    b_in     = 8'd9;
    @(negedge clk_in);
    start_in = 1'b0;
    check("b2b_accept", 32'(busy_out), 32'd1);
    repeat (5) @(negedge clk_in);
    check("b2b_hold", 32'(result_out), 32'h1E);
    wait_done(n);
    check("b2b_result", 32'(result_out), 32'h3F);
    @(negedge clk_in);
    a_in     = 8'd3;
    b_in     = 8'd5;
    start_in = 1'b1;
    dones    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (done_out) dones++;
    end
    start_in = 1'b0;
    wait_idle();
    check("held_result", 32'(result_out), 32'h0F);
    check("held_dones", 32'(dones), EARLY ? 32'd3 : 32'd1);
    start_in = 1'b1;
    @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    a_in = 8'hAA;
    b_in = 8'h55;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(n);
    check("midstart_result", 32'(result_out), 32'h0F);
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = 8'd7;
    b_in     = 8'd9;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (9) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_done", 32'(done_out), 32'd0);
    check("midrst_result", 32'(result_out), 32'd0);
    mul(8'd7, 8'd9, r, n);
    check("7x9_result", 32'(r), 32'h3F);
`ifdef MUL_EARLY_EXIT_EN
    mul(8'd3, 8'd1, r, n);
    check("early_3x1_result", 32'(r), 32'h03);
    check("early_3x1_latency", 32'(n), 32'd4);
    mul(8'd9, 8'd0, r, n);
    check("early_9x0_result", 32'(r), 32'h00);
    check("early_9x0_latency", 32'(n), 32'd1);
`endif
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = (i % 8 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      mul(a, b, r, n);
      check("rand_result", 32'(r), 32'(prod8(a, b)));
      check("rand_latency", 32'(n), 32'(lat(b)));
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
